// File: rtl/seg_scan_decoder.sv
// Receive side of an 8-digit multiplexed 7-segment scan bus: synchronises, debounces each
// scan slot and decodes every glyph back to a hex nibble per digit, with frame/error/stall flags.
module seg_scan_decoder #(
   parameter int STABLE_CYC = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [7:0]  SEG_COM,
   input  logic [6:0]  SEG_DATA,
   input  logic        CLR,
   output logic [31:0] DIGIT_VAL,
   output logic [7:0]  DIGIT_OK,
   output logic        FRAME_VLD,
   output logic        BAD_COM,
   output logic        STALE
);
   localparam int          CNT_W = $clog2(STABLE_CYC) + 1;
   localparam int          TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [14:0] BLANK = {8'hFF, 7'h00};

   typedef enum logic [1:0] {SETTLE, CAPTURE, HELD} state_t;

   // Returns {legal, value}; unlisted segment codes are illegal.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      case (seg)
         7'b1111110: return 5'h10;
         7'b0110000: return 5'h11;
         7'b1101101: return 5'h12;
         7'b1111001: return 5'h13;
         7'b0110011: return 5'h14;
         7'b1011011: return 5'h15;
         7'b1011111: return 5'h16;
         7'b1110000: return 5'h17;
         7'b1111111: return 5'h18;
         7'b1111011: return 5'h19;
         7'b1110111: return 5'h1A;
         7'b0011111: return 5'h1B;
         7'b1001110: return 5'h1C;
         7'b0111101: return 5'h1D;
         7'b1001111: return 5'h1E;
         7'b1000111: return 5'h1F;
         default:    return 5'h00;
      endcase
   endfunction

   logic [14:0]      sync_p0, sync_p1, pat_p2;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             changed;
   logic [7:0]       sel, mask, mask_nxt;
   logic [4:0]       glyph;
   logic             sel_one, cap_digit, cap_bad, frame_now;
   logic [TMR_W-1:0] timer;

   // Stage p0/p1: two-flop synchroniser; p2 keeps the previous synchronised pattern
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_p0 <= BLANK;
         sync_p1 <= BLANK;
         pat_p2  <= BLANK;
      end else begin
         sync_p0 <= {SEG_COM, SEG_DATA};
         sync_p1 <= sync_p0;
         pat_p2  <= sync_p1;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= SETTLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      changed   = (sync_p1 != pat_p2);
      case (state)
         SETTLE: begin
            if (changed) begin
               cnt_nxt = CNT_W'(1);
            end else begin
               if (cnt < CNT_W'(STABLE_CYC)) cnt_nxt = cnt + 1'b1;
               if (cnt >= CNT_W'(STABLE_CYC - 1)) state_nxt = CAPTURE;
            end
         end
         CAPTURE, HELD: begin
            if (changed) begin
               state_nxt = SETTLE;
               cnt_nxt   = CNT_W'(1);
            end else begin
               state_nxt = HELD;
            end
         end
         default: state_nxt = SETTLE;
      endcase
   end

   // Stage p3: capture action on the pattern that completed its hold (held in pat_p2)
   always_comb begin
      sel       = ~pat_p2[14:7];
      glyph     = decode_glyph(pat_p2[6:0]);
      sel_one   = (sel != 8'h00) && ((sel & (sel - 1'b1)) == 8'h00);
      cap_digit = (state == CAPTURE) && sel_one;
      cap_bad   = (state == CAPTURE) && (sel != 8'h00) && !sel_one;
      mask_nxt  = cap_digit ? (mask | sel) : mask;
      frame_now = (mask_nxt == 8'hFF);
   end

   // Select bit j (active low) maps to nibble [4j+3:4j] and DIGIT_OK[j].
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         DIGIT_VAL <= '0;
         DIGIT_OK  <= '0;
      end else if (cap_digit) begin
         for (int j = 0; j < 8; j++) begin
            if (sel[j]) begin
               DIGIT_OK[j] <= glyph[4];
               if (glyph[4]) DIGIT_VAL[4*j +: 4] <= glyph[3:0];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         BAD_COM   <= 1'b0;
         FRAME_VLD <= 1'b0;
         mask      <= '0;
         timer     <= '0;
      end else if (CLR) begin
         BAD_COM   <= 1'b0;
         FRAME_VLD <= 1'b0;
         mask      <= '0;
         timer     <= '0;
      end else begin
         BAD_COM   <= BAD_COM | cap_bad;
         FRAME_VLD <= frame_now;
         mask      <= frame_now ? 8'h00 : mask_nxt;
         if (cap_digit)                        timer <= '0;
         else if (timer != TMR_W'(TIMEOUT))    timer <= timer + 1'b1;
      end
   end

   assign STALE = (timer == TMR_W'(TIMEOUT));

endmodule
